data_memory_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported data memory. It shares the memory between the processor load/store path (port 0) and a secondary master such as a debug or DMA engine (port 1). Each transaction runs through a fixed three-state sequence. The block range-checks every address against the data segment window, blocks writes that fall outside it, and returns registered read data with a per-port done/error pulse.

---
 rtl/data_memory_arbiter_if.sv | 23 ++
 rtl/data_memory_arbiter.sv | 153 +++++++++++++++
 tb/tb_data_memory_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// Requester-side bus of the data memory arbiter: request/operands in, grant/done/error/read data out.
interface data_memory_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  gnt_o;
    logic                  done_o;
    logic                  err_o;
    logic [DATA_WIDTH-1:0] rdata_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, done_o, err_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, done_o, err_o, rdata_o
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter/sequencer (IDLE -> ACCESS -> RESP) in front of the single-ported data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module data_memory_arbiter #(
    parameter int unsigned           MEMORY_DEPTH = 64,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h10010000
) (
    input  logic                  clk,
    input  logic                  reset,
    data_memory_arbiter_if.slave  m0,
    data_memory_arbiter_if.slave  m1,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic                  winner;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] rd_capture;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic rr_last_q, rr_last_d;

    // Contested request goes to the port not served last; a lone request always wins.
    always_comb begin
        winner = !m0.req_i;
        if (m0.req_i && m1.req_i) begin
            winner = !rr_last_q;
        end
    end
`else
    always_comb begin
        winner = !m0.req_i;
    end
`endif

    // Window check on the latched byte address; the subtraction never wraps because addr >= base is required.
    always_comb begin
        offset   = addr_q - BASE_ADDRESS;
        in_range = (addr_q >= BASE_ADDRESS) && (addr_q[1:0] == 2'b00)
                   && ((offset >> 2) < DATA_WIDTH'(MEMORY_DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        rr_last_d   = rr_last_q;
`endif
        rd_capture  = '0;
        mem_we_o    = 1'b0;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        m0.gnt_o    = 1'b0;
        m0.done_o   = 1'b0;
        m0.err_o    = 1'b0;
        m0.rdata_o  = rdata0_q;
        m1.gnt_o    = 1'b0;
        m1.done_o   = 1'b0;
        m1.err_o    = 1'b0;
        m1.rdata_o  = rdata1_q;

        case (state_q)
            IDLE: begin
                if (m0.req_i || m1.req_i) begin
                    owner_d   = winner;
                    we_d      = winner ? m1.we_i    : m0.we_i;
                    addr_d    = winner ? m1.addr_i  : m0.addr_i;
                    wdata_d   = winner ? m1.wdata_i : m0.wdata_i;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    rr_last_d = winner;
`endif
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                mem_we_o   = we_q && in_range && !reset;
                m0.gnt_o   = !owner_q;
                m1.gnt_o   = owner_q;
                fault_d    = !in_range;
                rd_capture = (we_q || !in_range) ? '0 : mem_rdata_i;
                if (owner_q) begin
                    rdata1_d = rd_capture;
                end else begin
                    rdata0_d = rd_capture;
                end
                state_d    = RESP;
            end
            RESP: begin
                m0.done_o = !owner_q;
                m0.err_o  = !owner_q && fault_q;
                m1.done_o = owner_q;
                m1.err_o  = owner_q && fault_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            fault_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            fault_q   <= fault_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: random and directed transactions against a queue-based reference model.
module tb_data_memory_arbiter;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned DW    = 32;
    localparam logic [31:0] BASE  = 32'h10010000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        load_mem;

    data_memory_arbiter_if #(.DATA_WIDTH(DW)) m0_if ();
    data_memory_arbiter_if #(.DATA_WIDTH(DW)) m1_if ();

    data_memory_arbiter #(
        .MEMORY_DEPTH (DEPTH),
        .DATA_WIDTH   (DW),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0          (m0_if),
        .m1          (m1_if),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_port;

    logic [31:0] phys_mem [DEPTH];
    logic [31:0] ref_mem  [DEPTH];
    exp_t        exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Window rule written as a byte range, independent of the design's word-index form.
    function automatic bit in_window(input logic [31:0] a);
        longint unsigned ua;
        ua = a;
        return (ua >= BASE) && (ua < longint'(BASE) + 4 * DEPTH) && (ua % 4 == 0);
    endfunction

    // Memory behind the arbiter: combinational read, write at the rising edge.
    always_comb begin
        logic [31:0] w;
        w = (mem_addr - BASE) >> 2;
        mem_rdata = mem_addr ^ 32'hA5A5_5A5A;
        if (mem_addr >= BASE && w < DEPTH) mem_rdata = phys_mem[w[5:0]];
    end

    always @(posedge clk) begin
        logic [31:0] w;
        w = (mem_addr - BASE) >> 2;
        if (load_mem) begin
            for (int i = 0; i < DEPTH; i++) phys_mem[i] <= ref_mem[i];
        end else if (mem_we && mem_addr >= BASE && w < DEPTH) begin
            phys_mem[w[5:0]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, req, $time);
        end
    endtask

    function automatic logic [31:0] rd_of(input int p);
        return (p == 0) ? m0_if.rdata_o : m1_if.rdata_o;
    endfunction

    function automatic logic err_of(input int p);
        return (p == 0) ? m0_if.err_o : m1_if.err_o;
    endfunction

    function automatic logic gnt_of(input int p);
        return (p == 0) ? m0_if.gnt_o : m1_if.gnt_o;
    endfunction

    function automatic op_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        op_t o;
        o.we = we; o.addr = addr; o.wdata = wdata;
        return o;
    endfunction

    function automatic op_t rand_op();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            6:       a = BASE - 4 * $urandom_range(1, 4);
            7:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
            8:       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
            9:       a = $urandom;
            default: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
        endcase
        return mk(1'($urandom_range(0, 1)), a, $urandom);
    endfunction

    // Reference model: serve pending queues in arbitration order, one whole transaction at a time.
    function automatic void predict(input op_t q0[$], input op_t q1[$]);
        int   w, idx;
        op_t  o;
        exp_t e;
        while (q0.size() + q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                w = (last_port == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else begin
                w = (q0.size() > 0) ? 0 : 1;
            end
            o = (w == 0) ? q0.pop_front() : q1.pop_front();
            e.port  = w;
            e.err   = !in_window(o.addr);
            e.rdata = '0;
            if (!e.err) begin
                idx = int'((o.addr - BASE) / 4);
                if (o.we) ref_mem[idx] = o.wdata;
                else      e.rdata = ref_mem[idx];
            end
            exp_q.push_back(e);
            last_port = w;
        end
    endfunction

    // Monitor: pops the scoreboard on every done pulse and watches the memory write strobe.
    logic        gnt_prev [2];
    logic [31:0] last_rd  [2];
    initial begin
        gnt_prev[0] = 1'b0; gnt_prev[1] = 1'b0;
        last_rd[0]  = '0;   last_rd[1]  = '0;
    end

    always @(negedge clk) begin
        int   p;
        exp_t e;
        if (reset) begin
            last_rd[0] = '0;
            last_rd[1] = '0;
        end
        if (m0_if.done_o || m1_if.done_o) begin
            p = m1_if.done_o ? 1 : 0;
            check("done_exclusive", 32'(m0_if.done_o & m1_if.done_o), 32'd0);
            check("done_after_gnt", 32'(gnt_prev[p]), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: port %0d done, required none pending", p);
            end else begin
                e = exp_q.pop_front();
                check("owner", 32'(p), 32'(e.port));
                check("rdata", rd_of(p), e.rdata);
                check("err", 32'(err_of(p)), 32'(e.err));
                check("other_port_rdata_hold", rd_of(1 - p), last_rd[1 - p]);
                check("other_port_err", 32'(err_of(1 - p)), 32'd0);
                last_rd[p] = e.rdata;
            end
        end
        if (mem_we) begin
            check("mem_we_legal", 32'(in_window(mem_addr) && (m0_if.gnt_o || m1_if.gnt_o) && !reset), 32'd1);
        end
        gnt_prev[0] = m0_if.gnt_o;
        gnt_prev[1] = m1_if.gnt_o;
    end

    task automatic set_port(input int p, input logic req, input op_t o);
        if (p == 0) begin
            m0_if.req_i = req; m0_if.we_i = o.we; m0_if.addr_i = o.addr; m0_if.wdata_i = o.wdata;
        end else begin
            m1_if.req_i = req; m1_if.we_i = o.we; m1_if.addr_i = o.addr; m1_if.wdata_i = o.wdata;
        end
    endtask

    // Requester: keeps req high across its ops, changes operands only after a grant.
    task automatic drive_port(input int p, input op_t ops[$], input bit solo);
        int start, prev_gnt;
        bit got;
        start = 0; prev_gnt = 0;
        for (int i = 0; i < ops.size(); i++) begin
            set_port(p, 1'b1, ops[i]);
            if (i == 0) start = cyc;
            got = 1'b0;
            for (int k = 0; k < 400 && !got; k++) begin
                @(negedge clk);
                got = gnt_of(p);
            end
            if (!got) begin
                n_checks++;
                n_fail++;
                $display("FAIL gnt_timeout: port %0d got no grant, required one within 400 cycles", p);
                set_port(p, 1'b0, ops[i]);
                return;
            end
            if (solo) check("gnt_latency", 32'(cyc), 32'((i == 0) ? start + 1 : prev_gnt + 3));
            prev_gnt = cyc;
            @(negedge clk);
        end
        set_port(p, 1'b0, mk(1'b0, '0, '0));
    endtask

    task automatic check_mem();
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (phys_mem[i] !== ref_mem[i]) bad++;
        check("mem_image_mismatches", 32'(bad), 32'd0);
    endtask

    task automatic run_batch(input op_t q0[$], input op_t q1[$]);
        predict(q0, q1);
        fork
            drive_port(0, q0, q1.size() == 0);
            drive_port(1, q1, q0.size() == 0);
        join
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check_mem();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'({m0_if.gnt_o, m1_if.gnt_o}), 32'd0);
        check({tag, "_done"},  32'({m0_if.done_o, m1_if.done_o}), 32'd0);
        check({tag, "_err"},   32'({m0_if.err_o, m1_if.err_o}), 32'd0);
        check({tag, "_rdata0"}, m0_if.rdata_o, 32'd0);
        check({tag, "_rdata1"}, m1_if.rdata_o, 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t q0 [$];
        op_t q1 [$];
        op_t o;
        int  start;

        reset    = 1'b1;
        load_mem = 1'b1;
        set_port(0, 1'b0, mk(1'b0, '0, '0));
        set_port(1, 1'b0, mk(1'b0, '0, '0));
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        last_port = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        load_mem = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check_mem();

        // Write then read back word 2 on port 0.
        q0.delete(); q1.delete();
        q0.push_back(mk(1'b1, 32'h10010008, 32'hDEADBEEF));
        q0.push_back(mk(1'b0, 32'h10010008, 32'h0));
        run_batch(q0, q1);
        check("word2_written", phys_mem[2], 32'hDEADBEEF);

        // Port 1 faults: below the base and one word past the end.
        q0.delete(); q1.delete();
        q1.push_back(mk(1'b0, 32'h1000FFFC, 32'h0));
        q1.push_back(mk(1'b1, 32'h10010100, 32'h12345678));
        run_batch(q0, q1);

        // Misaligned write, then last word of the window.
        q0.delete(); q1.delete();
        q0.push_back(mk(1'b1, 32'h10010002, 32'hCAFEF00D));
        q1.push_back(mk(1'b1, 32'h100100FC, 32'h600DF00D));
        q1.push_back(mk(1'b0, 32'h100100FC, 32'h0));
        run_batch(q0, q1);
        q0.delete(); q1.delete();
        q0.push_back(mk(1'b0, 32'h100100FC, 32'h0));
        run_batch(q0, q1);

        // Reset during the ACCESS cycle of a write to word 4.
        o = mk(1'b1, 32'h10010010, ~ref_mem[4]);
        set_port(0, 1'b1, o);
        @(negedge clk);
        check("rst_test_gnt", 32'(m0_if.gnt_o), 32'd1);
        reset = 1'b1;
        set_port(0, 1'b0, o);
        @(negedge clk);
        check_reset_outputs("after_mid_reset");
        reset     = 1'b0;
        last_port = 1;
        repeat (3) @(negedge clk);
        check("word4_unchanged", phys_mem[4], ref_mem[4]);
        check_mem();

        // Both ports requesting continuously, first contest after reset.
        q0.delete(); q1.delete();
        for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, BASE + 4 * $urandom_range(0, DEPTH - 1), '0));
        for (int i = 0; i < 2; i++) q1.push_back(mk(1'b0, BASE + 4 * $urandom_range(0, DEPTH - 1), '0));
        run_batch(q0, q1);

        // Port 0 drops req in the ACCESS cycle; the transaction still completes, no second grant.
        q0.delete(); q1.delete();
        o = mk(1'b0, BASE + 4 * $urandom_range(0, DEPTH - 1), '0);
        q0.push_back(o);
        predict(q0, q1);
        set_port(0, 1'b1, o);
        start = cyc;
        @(negedge clk);
        check("drop_gnt_e1", 32'(m0_if.gnt_o), 32'd1);
        check("drop_gnt_cycle", 32'(cyc), 32'(start + 1));
        set_port(0, 1'b0, o);
        @(negedge clk);
        check("drop_done_e2", 32'(m0_if.done_o), 32'd1);
        repeat (6) begin
            @(negedge clk);
            check("no_second_gnt", 32'(m0_if.gnt_o | m1_if.gnt_o), 32'd0);
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Random mixes of solo and contended traffic.
        for (int b = 0; b < 30; b++) begin
            int n0, n1;
            q0.delete(); q1.delete();
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++) q0.push_back(rand_op());
            for (int i = 0; i < n1; i++) q1.push_back(rand_op());
            run_batch(q0, q1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
